// File: rtl/conv_window_buffer_if.sv
// ---------------------------------------------------------------------------
// conv_window_buffer_if
//   Handshake bundle for conv_window_buffer: the raster pixel stream going in
//   (3 channels per beat) and the 3x3x3 window stream coming out.
//
//   Pixel stream : in_valid, in_ready, in_c1..in_c3 (signed, DATA_W each)
//   Window stream: win_valid, win_ready, win_c1..win_c3 (9 x DATA_W each,
//                  element k at bits [k*DATA_W-1 -: DATA_W], k=1 top-left),
//                  win_row, win_col (window origin), frame_done (1-cycle pulse)
//
//   modport slave : the window buffer itself
//   modport master: the environment (pixel source + window consumer)
// ---------------------------------------------------------------------------
interface conv_window_buffer_if #(
    parameter int DATA_W = 9,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam int WIN_W = 9 * DATA_W;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_c1;
    logic signed [DATA_W-1:0] in_c2;
    logic signed [DATA_W-1:0] in_c3;

    logic                     win_valid;
    logic                     win_ready;
    logic        [WIN_W-1:0]  win_c1;
    logic        [WIN_W-1:0]  win_c2;
    logic        [WIN_W-1:0]  win_c3;
    logic        [ROW_W-1:0]  win_row;
    logic        [COL_W-1:0]  win_col;
    logic                     frame_done;

    modport slave (
        input  in_valid, in_c1, in_c2, in_c3, win_ready,
        output in_ready, win_valid, win_c1, win_c2, win_c3, win_row, win_col, frame_done
    );

    modport master (
        output in_valid, in_c1, in_c2, in_c3, win_ready,
        input  in_ready, win_valid, win_c1, win_c2, win_c3, win_row, win_col, frame_done
    );
endinterface

// File: rtl/conv_window_buffer.sv
// ---------------------------------------------------------------------------
// conv_window_buffer
//   Line-buffer / sliding-window generator in front of the layer-1 conv PE.
//   Takes a raster-order stream of 3-channel pixels and emits every unpadded
//   3x3 window of all three channels at once, (IMG_H-2)*(IMG_W-2) per frame,
//   at up to one window per cycle with ready/valid back-pressure.
//
//   Ports
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     clr    : synchronous frame abort (counters to 0, pending window dropped)
//     bus    : conv_window_buffer_if.slave (pixel in, window out, frame_done)
// ---------------------------------------------------------------------------
module conv_window_buffer #(
    parameter int DATA_W = 9,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    conv_window_buffer_if.slave bus
);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam int WIN_W = 9 * DATA_W;
    localparam int PIX_W = 3 * DATA_W;

    // Line buffers hold all three channels of one pixel per entry:
    // r_lb1 = row r-1, r_lb2 = row r-2, indexed by column.
    logic [PIX_W-1:0] r_lb1 [IMG_W];
    logic [PIX_W-1:0] r_lb2 [IMG_W];

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;

    // The shifting window doubles as the output register. It only moves on an
    // accepted beat, and a beat is only accepted when the current window is
    // either invalid or being consumed, so a stalled window never changes.
    logic [WIN_W-1:0] r_win [3];
    logic             r_win_valid;
    logic [ROW_W-1:0] r_win_row;
    logic [COL_W-1:0] r_win_col;
    logic             r_frame_done;

    logic             w_accept;
    logic             w_handover;
    logic             w_last_col;
    logic             w_last_row;
    logic             w_win_pos;
    logic             w_last_win;
    logic [PIX_W-1:0] w_pix;
    logic [PIX_W-1:0] w_lb1_rd;
    logic [PIX_W-1:0] w_lb2_rd;

    // Shift the 3x3 window one column left and insert a new right column.
    // A right shift of the packed vector moves element k+1 into slot k for
    // every element; the right-column slots (3, 6, 9) are then overwritten.
    function automatic logic [WIN_W-1:0] shift_col(
        input logic [WIN_W-1:0]  win,
        input logic [DATA_W-1:0] top,
        input logic [DATA_W-1:0] mid,
        input logic [DATA_W-1:0] bot
    );
        logic [WIN_W-1:0] res;
        res = win >> DATA_W;
        res[3*DATA_W-1 -: DATA_W] = top;
        res[6*DATA_W-1 -: DATA_W] = mid;
        res[9*DATA_W-1 -: DATA_W] = bot;
        return res;
    endfunction

    assign bus.in_ready = !clr && (!r_win_valid || bus.win_ready);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_handover   = r_win_valid && bus.win_ready;

    assign w_last_col = (r_col == COL_W'(IMG_W - 1));
    assign w_last_row = (r_row == ROW_W'(IMG_H - 1));
    // Rows 0/1 and columns 0/1 never complete a window; this is also what
    // keeps stale line-buffer data and the previous row's tail columns out.
    assign w_win_pos  = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
    assign w_last_win = (r_win_row == ROW_W'(IMG_H - 3)) && (r_win_col == COL_W'(IMG_W - 3));

    assign w_pix    = {bus.in_c3, bus.in_c2, bus.in_c1};
    assign w_lb1_rd = r_lb1[r_col];
    assign w_lb2_rd = r_lb2[r_col];

    // NOTE: line-buffer storage has no reset; rows 0/1 of every frame refill
    // it before any window can read it, so a reset would only cost area.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb2[r_col] <= w_lb1_rd;
            r_lb1[r_col] <= w_pix;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row        <= '0;
            r_col        <= '0;
            r_win        <= '{default: '0};
            r_win_valid  <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_frame_done <= 1'b0;
        end else if (clr) begin
            r_row        <= '0;
            r_col        <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_handover && w_last_win;

            if (w_accept) begin
                for (int ch = 0; ch < 3; ch++) begin
                    r_win[ch] <= shift_col(r_win[ch],
                                           w_lb2_rd[ch*DATA_W +: DATA_W],
                                           w_lb1_rd[ch*DATA_W +: DATA_W],
                                           w_pix[ch*DATA_W +: DATA_W]);
                end
                r_win_valid <= w_win_pos;
                if (w_win_pos) begin
                    r_win_row <= r_row - ROW_W'(2);
                    r_win_col <= r_col - COL_W'(2);
                end

                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end else if (bus.win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    assign bus.win_c1     = r_win[0];
    assign bus.win_c2     = r_win[1];
    assign bus.win_c3     = r_win[2];
    assign bus.win_valid  = r_win_valid;
    assign bus.win_row    = r_win_row;
    assign bus.win_col    = r_win_col;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_conv_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_conv_window_buffer
//   Self-checking bench for conv_window_buffer on a 4x4 image. A frame-array
//   model builds each expected window when its bottom-right pixel is
//   accepted and queues it; the queue front is compared with the DUT output
//   on every cycle the DUT shows a valid window, and popped on hand-over.
// ---------------------------------------------------------------------------
module tb_conv_window_buffer;
    localparam int DATA_W = 9;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int COL_W  = $clog2(IMG_W);
    localparam int WIN_W  = 9 * DATA_W;
    localparam int BEATS  = IMG_W * IMG_H;

    typedef struct packed {
        logic [WIN_W-1:0] c1;
        logic [WIN_W-1:0] c2;
        logic [WIN_W-1:0] c3;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } win_t;

    // mode: 0 ramp, 1 ramp offset by frame, 2 all -256, 3 all +255, 4 mixed extremes
    // rpat: 0 win_ready=1, 1 win_ready toggles, 2 random ready and valid
    typedef struct {
        int mode;
        int rpat;
        int n_frames;
        int exp_windows;
        int exp_done;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;

    conv_window_buffer_if #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

    conv_window_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    win_t                     q[$];
    logic signed [DATA_W-1:0] mpix [IMG_H][IMG_W][3];
    int                       mr, mc;
    logic                     exp_fd;
    int                       n_pass, n_total;
    int                       win_seen, done_seen;
    win_t                     first_act, last_act;

    int first_ref [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int last_ref  [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic signed [DATA_W-1:0] gen_pix(input int mode, input int f,
                                                          input int r, input int c, input int ch);
        int v;
        case (mode)
            0:       v = r * IMG_W + c;
            1:       v = r * IMG_W + c + 32 * f;
            2:       v = -256;
            3:       v = 255;
            default: v = ((r + c) % 2 == 1) ? 255 : -256;
        endcase
        if (mode <= 1) begin
            if (ch == 1) v = v + 16;
            else if (ch == 2) v = -v;
        end else if (mode == 4 && ch == 1) begin
            v = -1 - v;
        end
        return DATA_W'(v);
    endfunction

    function automatic logic [WIN_W-1:0] pack9(input int e [9], input bit neg);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) w[k*DATA_W +: DATA_W] = DATA_W'(neg ? -e[k] : e[k]);
        return w;
    endfunction

    function automatic win_t model_win(input int r, input int c);
        win_t w;
        w.row = ROW_W'(r - 2);
        w.col = COL_W'(c - 2);
        for (int k = 0; k < 9; k++) begin
            w.c1[k*DATA_W +: DATA_W] = mpix[r-2+k/3][c-2+k%3][0];
            w.c2[k*DATA_W +: DATA_W] = mpix[r-2+k/3][c-2+k%3][1];
            w.c3[k*DATA_W +: DATA_W] = mpix[r-2+k/3][c-2+k%3][2];
        end
        return w;
    endfunction

    // One clock cycle: drive on the falling edge, check 1 ns later, then
    // advance the model to what the next rising edge should do.
    task automatic cycle(input logic v, input logic signed [DATA_W-1:0] p1,
                         input logic signed [DATA_W-1:0] p2, input logic signed [DATA_W-1:0] p3,
                         input logic wr, input logic cl, output logic accepted);
        win_t act;
        logic exp_valid, exp_ready;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_c1     = p1;
        bus.in_c2     = p2;
        bus.in_c3     = p3;
        bus.win_ready = wr;
        clr           = cl;
        #1;
        exp_valid = (q.size() != 0);
        exp_ready = !cl && (!exp_valid || wr);
        act       = {bus.win_c1, bus.win_c2, bus.win_c3, bus.win_row, bus.win_col};
        check("in_ready",   256'(bus.in_ready),   256'(exp_ready));
        check("win_valid",  256'(bus.win_valid),  256'(exp_valid));
        check("frame_done", 256'(bus.frame_done), 256'(exp_fd));
        if (bus.frame_done) done_seen++;
        if (bus.win_valid && exp_valid) check("window", 256'(act), 256'(q[0]));
        if (bus.win_valid && wr) begin
            if (win_seen == 0) first_act = act;
            last_act = act;
            win_seen++;
        end
        accepted = v && exp_ready;
        exp_fd   = 1'b0;
        if (cl) begin
            q.delete();
            mr = 0;
            mc = 0;
        end else begin
            if (exp_valid && wr) begin
                exp_fd = (q[0].row == ROW_W'(IMG_H - 3)) && (q[0].col == COL_W'(IMG_W - 3));
                void'(q.pop_front());
            end
            if (accepted) begin
                mpix[mr][mc][0] = p1;
                mpix[mr][mc][1] = p2;
                mpix[mr][mc][2] = p3;
                if (mr >= 2 && mc >= 2) q.push_back(model_win(mr, mc));
                mc++;
                if (mc == IMG_W) begin
                    mc = 0;
                    mr = (mr == IMG_H - 1) ? 0 : mr + 1;
                end
            end
        end
    endtask

    task automatic send_beats(input int mode, input int rpat, input int nbeats);
        int   b, cyc, f, p;
        logic acc, wr, v;
        b   = 0;
        cyc = 0;
        while (b < nbeats && cyc < 2000) begin
            f  = b / BEATS;
            p  = b % BEATS;
            v  = 1'b1;
            case (rpat)
                0:       wr = 1'b1;
                1:       wr = (cyc % 2 == 0);
                default: begin
                    wr = ($urandom_range(0, 1) == 1);
                    v  = ($urandom_range(0, 3) != 0);
                end
            endcase
            cycle(v, gen_pix(mode, f, p / IMG_W, p % IMG_W, 0), gen_pix(mode, f, p / IMG_W, p % IMG_W, 1),
                  gen_pix(mode, f, p / IMG_W, p % IMG_W, 2), wr, 1'b0, acc);
            if (acc) b++;
            cyc++;
        end
        if (b < nbeats) check("send_timeout", 256'(b), 256'(nbeats));
    endtask

    task automatic drain(input int rpat);
        int   n;
        logic acc, wr;
        n = 0;
        while ((q.size() != 0 || exp_fd) && n < 40) begin
            wr = (rpat == 1) ? (n % 2 == 1) : 1'b1;
            cycle(1'b0, '0, '0, '0, wr, 1'b0, acc);
            n++;
        end
        if (n >= 40) check("drain_timeout", 256'(q.size()), 256'(0));
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2;
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        check("rst_win_valid",  256'(bus.win_valid),  256'(0));
        check("rst_frame_done", 256'(bus.frame_done), 256'(0));
        check("rst_window", 256'({bus.win_c1, bus.win_c2, bus.win_c3, bus.win_row, bus.win_col}), 256'(0));
        q.delete();
        mr     = 0;
        mc     = 0;
        exp_fd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic full_frame_check(input string tag);
        win_seen  = 0;
        done_seen = 0;
        send_beats(0, 0, BEATS);
        drain(0);
        check({tag, "_windows"}, 256'(win_seen), 256'(4));
        check({tag, "_done"},    256'(done_seen), 256'(1));
    endtask

    vec_t vecs [6];
    logic acc;

    initial begin
        vecs[0] = '{mode: 0, rpat: 0, n_frames: 1, exp_windows: 4, exp_done: 1};
        vecs[1] = '{mode: 0, rpat: 1, n_frames: 1, exp_windows: 4, exp_done: 1};
        vecs[2] = '{mode: 1, rpat: 0, n_frames: 2, exp_windows: 8, exp_done: 2};
        vecs[3] = '{mode: 2, rpat: 0, n_frames: 1, exp_windows: 4, exp_done: 1};
        vecs[4] = '{mode: 3, rpat: 1, n_frames: 1, exp_windows: 4, exp_done: 1};
        vecs[5] = '{mode: 4, rpat: 2, n_frames: 2, exp_windows: 8, exp_done: 2};

        n_pass = 0;
        n_total = 0;
        mr = 0;
        mc = 0;
        exp_fd = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_c1     = '0;
        bus.in_c2     = '0;
        bus.in_c3     = '0;
        bus.win_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready",   256'(bus.in_ready),   256'(1));
        check("rst_win_valid",  256'(bus.win_valid),  256'(0));
        check("rst_frame_done", 256'(bus.frame_done), 256'(0));
        check("rst_window", 256'({bus.win_c1, bus.win_c2, bus.win_c3, bus.win_row, bus.win_col}), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            win_seen  = 0;
            done_seen = 0;
            send_beats(vecs[i].mode, vecs[i].rpat, vecs[i].n_frames * BEATS);
            drain(vecs[i].rpat);
            check($sformatf("vec%0d_windows", i), 256'(win_seen),  256'(vecs[i].exp_windows));
            check($sformatf("vec%0d_done", i),    256'(done_seen), 256'(vecs[i].exp_done));
            if (i == 0) begin
                check("first_c1", 256'(first_act.c1), 256'(pack9(first_ref, 1'b0)));
                check("first_c3", 256'(first_act.c3), 256'(pack9(first_ref, 1'b1)));
                check("last_c1",  256'(last_act.c1),  256'(pack9(last_ref, 1'b0)));
                check("last_pos", 256'({last_act.row, last_act.col}), 256'({2'd1, 2'd1}));
            end
        end

        // Reset after 6 beats, then a full frame
        send_beats(0, 0, 6);
        reset_pulse();
        full_frame_check("rst6");

        // Reset while a window is stalled at the output
        send_beats(0, 0, 11);
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, acc);
        reset_pulse();
        full_frame_check("rst11");

        // clr coincident with beat 10: beat dropped, next beat is row 0 col 0
        send_beats(0, 0, 9);
        cycle(1'b1, gen_pix(0, 0, 2, 1, 0), gen_pix(0, 0, 2, 1, 1), gen_pix(0, 0, 2, 1, 2),
              1'b1, 1'b1, acc);
        full_frame_check("clr10");

        // clr while a window is stalled: window must be dropped
        send_beats(0, 0, 11);
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, acc);
        full_frame_check("clr_stall");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
